// File: rtl/ctrl_loader_pkg.sv
// rtl/ctrl_loader_pkg.sv - shared states, err bit indices and beat-count helper for the control-word loader
package ctrl_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LOADED = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_WD  = 1;

    function automatic int beats_per_word(input int ctrl_width, input int beat_width);
        return (ctrl_width + beat_width - 1) / beat_width;
    endfunction

endpackage

// File: rtl/ctrl_program_loader_beat_packer.sv
// rtl/ctrl_program_loader_beat_packer.sv - packs host beats into zero-padded control words
import ctrl_loader_pkg::*;

module beat_packer #(
    parameter int CTRL_WIDTH = 72,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BEAT_WIDTH-1:0] beat_data,
    input  logic                  beat_fire,
    input  logic                  beat_last,
    output logic                  word_valid,
    output logic [CTRL_WIDTH-1:0] word_data
);

    localparam int B  = beats_per_word(CTRL_WIDTH, BEAT_WIDTH);
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    logic [CW-1:0]         cnt;
    logic [CTRL_WIDTH-1:0] acc;
    logic [CTRL_WIDTH-1:0] merged;

    // Slots above the current beat are still zero because acc clears after every word.
    always_comb begin
        merged = acc;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (cnt == CW'(i / BEAT_WIDTH)) begin
                merged[i] = beat_data[i % BEAT_WIDTH];
            end
        end
    end

    assign word_valid = beat_fire && (beat_last || cnt == CW'(B - 1));
    assign word_data  = merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (beat_fire) begin
            if (word_valid) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                acc <= merged;
            end
        end
    end

endmodule

// File: rtl/ctrl_program_loader.sv
// rtl/ctrl_program_loader.sv - loads control words into the tester BRAM and runs it; LOADER_WATCHDOG_EN adds a run watchdog
import ctrl_loader_pkg::*;

module ctrl_program_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int CTRL_WIDTH = 72,
    parameter int BEAT_WIDTH = 32,
    parameter int WD_CYCLES  = 2**20
) (
    input  logic                  CLK_100,
    input  logic                  RST,
    input  logic [BEAT_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  go,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [CTRL_WIDTH-1:0] bram_din,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic                  START,
    input  logic                  COMPLETED,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [1:0]            err,
    output logic [2:0]            debug_state
);

    localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state, state_nx;
    logic                  fin_pend;
    logic                  seen_run;
    logic                  beat_fire;
    logic                  word_valid;
    logic [CTRL_WIDTH-1:0] word_data;
    logic [ADDR_WIDTH:0]   wc_base;
    logic                  wd_expired;

`ifdef LOADER_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;
    assign wd_expired = (state == S_RUN) && (wd_cnt == WDW'(WD_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    // While the final write is in flight the FSM stays in LOAD but refuses beats.
    assign s_ready     = !RST && ((state == S_IDLE) || (state == S_LOAD && !fin_pend));
    assign beat_fire   = s_valid && s_ready;
    assign wc_base     = (state == S_IDLE) ? '0 : word_count;
    assign START       = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign debug_state = state;

    beat_packer #(
        .CTRL_WIDTH(CTRL_WIDTH),
        .BEAT_WIDTH(BEAT_WIDTH)
    ) u_packer (
        .clk       (CLK_100),
        .rst       (RST),
        .beat_data (s_data),
        .beat_fire (beat_fire),
        .beat_last (s_last),
        .word_valid(word_valid),
        .word_data (word_data)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (beat_fire) state_nx = S_LOAD;
            S_LOAD:   if (fin_pend) state_nx = S_LOADED;
            S_LOADED: if (go) state_nx = S_RUN;
            S_RUN:    if ((seen_run && COMPLETED) || wd_expired) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_100) begin
        if (RST) begin
            state      <= S_IDLE;
            fin_pend   <= 1'b0;
            seen_run   <= 1'b0;
            word_count <= '0;
            err        <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
        end else begin
            state    <= state_nx;
            bram_en  <= 1'b0;
            bram_we  <= 1'b0;
            fin_pend <= beat_fire && s_last;
            seen_run <= (state == S_RUN) && (seen_run || !COMPLETED);
            if (beat_fire && state == S_IDLE) begin
                word_count <= '0;
                err        <= '0;
            end
            if (word_valid) begin
                if (wc_base == WC_MAX) begin
                    err[ERR_OVF] <= 1'b1;
                end else begin
                    bram_en    <= 1'b1;
                    bram_we    <= 1'b1;
                    bram_addr  <= wc_base[ADDR_WIDTH-1:0];
                    bram_din   <= word_data;
                    word_count <= wc_base + 1'b1;
                end
            end
            if (wd_expired && !(seen_run && COMPLETED)) begin
                err[ERR_WD] <= 1'b1;
            end
        end
    end

`ifdef LOADER_WATCHDOG_EN
    always_ff @(posedge CLK_100) begin
        if (RST || state != S_RUN) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_program_loader.sv
// tb/tb_ctrl_program_loader.sv - directed table-driven bench for ctrl_program_loader
module tb_ctrl_program_loader;

    localparam int AW = 2;
    localparam int CW = 72;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] s_data;
    logic          s_valid, s_last, s_ready, go;
    logic [AW-1:0] bram_addr;
    logic [CW-1:0] bram_din;
    logic          bram_en, bram_we, start, completed, busy, done;
    logic [AW:0]   word_count;
    logic [1:0]    err;
    logic [2:0]    debug_state;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit overlap = 1'b0;

    always #5 clk = ~clk;

    ctrl_program_loader #(
        .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .BEAT_WIDTH(BW), .WD_CYCLES(16)
    ) dut (
        .CLK_100(clk), .RST(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .go(go),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_en(bram_en), .bram_we(bram_we),
        .START(start), .COMPLETED(completed),
        .busy(busy), .done(done), .word_count(word_count), .err(err),
        .debug_state(debug_state)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (bram_en && start) overlap = 1'b1;
    end

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
        logic          we;
        logic [AW-1:0] addr;
        logic [CW-1:0] din;
        logic [AW:0]   wc;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check("s_ready", s_ready, 1);
            s_data  = vt[i].data;
            s_valid = 1'b1;
            s_last  = vt[i].last;
            tick();
            check("bram_we", bram_en && bram_we, vt[i].we);
            if (vt[i].we) begin
                check("bram_addr", bram_addr, vt[i].addr);
                check("bram_din", bram_din, vt[i].din);
            end
            check("word_count", word_count, vt[i].wc);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [BW-1:0] ob[15];
    logic [CW-1:0] ow;
    int            d0;

    initial begin
        vt[0]  = '{32'h1, 1'b0, 1'b0, 2'd0, 72'h0, 3'd0};
        vt[1]  = '{32'h2, 1'b0, 1'b0, 2'd0, 72'h0, 3'd0};
        vt[2]  = '{32'h3, 1'b0, 1'b1, 2'd0, 72'h03_00000002_00000001, 3'd1};
        vt[3]  = '{32'h4, 1'b0, 1'b0, 2'd0, 72'h0, 3'd1};
        vt[4]  = '{32'h5, 1'b0, 1'b0, 2'd0, 72'h0, 3'd1};
        vt[5]  = '{32'h6, 1'b1, 1'b1, 2'd1, 72'h06_00000005_00000004, 3'd2};
        vt[6]  = '{32'h1, 1'b0, 1'b0, 2'd0, 72'h0, 3'd0};
        vt[7]  = '{32'h2, 1'b0, 1'b0, 2'd0, 72'h0, 3'd0};
        vt[8]  = '{32'h3, 1'b0, 1'b1, 2'd0, 72'h03_00000002_00000001, 3'd1};
        vt[9]  = '{32'h4, 1'b1, 1'b1, 2'd1, 72'h00_00000000_00000004, 3'd2};
        vt[10] = '{32'hA, 1'b0, 1'b0, 2'd0, 72'h0, 3'd0};
        vt[11] = '{32'hB, 1'b0, 1'b0, 2'd0, 72'h0, 3'd0};
        vt[12] = '{32'hC, 1'b1, 1'b1, 2'd0, 72'h0C_0000000B_0000000A, 3'd1};

        s_data = '0; s_valid = 1'b0; s_last = 1'b0; go = 1'b0; completed = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst state", debug_state, 0);
        check("rst START", start, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst bram_en", bram_en, 0);
        check("rst bram_din", bram_din, 0);
        check("rst word_count", word_count, 0);
        check("rst err", err, 0);
        check("rst s_ready", s_ready, 0);
        rst = 1'b0;
        tick();

        go = 1'b1;
        tick();
        go = 1'b0;
        check("go in idle ignored", debug_state, 0);

        // two full words
        apply(0, 5);
        check("final write s_ready", s_ready, 0);
        tick();
        check("loaded state", debug_state, 2);
        check("loaded bram_en", bram_en, 0);

        s_valid = 1'b1; s_data = 32'hDEAD;
        check("loaded s_ready", s_ready, 0);
        tick();
        s_valid = 1'b0;
        check("loaded no accept wc", word_count, 2);
        check("loaded no write", bram_en, 0);

        // normal run with COMPLETED handshake
        go = 1'b1;
        tick();
        go = 1'b0;
        check("run START rise", start, 1);
        check("run state", debug_state, 3);
        d0 = done_cnt;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("run START pre", start, 1);
        end
        completed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("run START mid", start, 1);
        end
        completed = 1'b1;
        tick();
        check("done state", debug_state, 4);
        check("done pulse", done, 1);
        check("done START low", start, 0);
        tick();
        check("back to idle", debug_state, 0);
        check("done low", done, 0);
        check("busy idle", busy, 0);
        check("done count", done_cnt - d0, 1);
        check("run err", err, 0);
        check("no bram_en under START", overlap, 0);

        // early s_last pads the word; first beat clears word_count
        apply(6, 9);
        check("partial err", err, 0);
        tick();
        check("partial loaded", debug_state, 2);

        // COMPLETED stuck low
        completed = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("wd START", start, 1);
        for (int i = 0; i < 15; i++) tick();
        check("wd still run", debug_state, 3);
        tick();
`ifdef LOADER_WATCHDOG_EN
        check("wd done state", debug_state, 4);
        check("wd done pulse", done, 1);
        check("wd err", err, 2'b10);
        check("wd START low", start, 0);
`else
        check("no wd state", debug_state, 3);
        check("no wd err", err, 0);
        for (int i = 0; i < 30; i++) tick();
        check("no wd stays run", debug_state, 3);
`endif
        completed = 1'b1;
        do_reset();

        // overflow: five words into four slots
        for (int i = 0; i < 15; i++) ob[i] = 32'h100 + i;
        for (int i = 0; i < 15; i++) begin
            s_data = ob[i]; s_valid = 1'b1; s_last = (i == 14);
            tick();
            if (i % 3 == 2 && i / 3 < 4) begin
                ow = {ob[i][7:0], ob[i-1], ob[i-2]};
                check("ovf we", bram_en && bram_we, 1);
                check("ovf addr", bram_addr, i / 3);
                check("ovf din", bram_din, ow);
            end else begin
                check("ovf no we", bram_en, 0);
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        check("ovf err", err, 2'b01);
        check("ovf word_count", word_count, 4);
        tick();
        check("ovf loaded", debug_state, 2);

        // reset in the middle of a word
        do_reset();
        s_valid = 1'b1;
        s_data = 32'h1; tick();
        s_data = 32'h2; tick();
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst state", debug_state, 0);
        check("midrst bram_en", bram_en, 0);
        check("midrst busy", busy, 0);
        check("midrst word_count", word_count, 0);
        rst = 1'b0;
        tick();
        apply(10, 12);
        tick();
        check("midrst reload state", debug_state, 2);
        check("no bram_en under START end", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_program_loader.md
# ctrl_program_loader

Host-side writer for the control-word BRAM that the LUD hardware tester plays back. Accepts a 32-bit valid/ready beat stream from the Zynq PS and packs beats into CTRL_WIDTH-bit control words. Writes the words sequentially from address 0 into the BRAM programming port. On host request it raises START, tracks the tester's COMPLETED handshake through a full run, then releases START and reports done.

## Interface
- ADDR_WIDTH, 12, control BRAM address width
- CTRL_WIDTH, 72, control word width
- BEAT_WIDTH, 32, host stream beat width
- WD_CYCLES, 2**20, watchdog limit in cycles (used only with watchdog enabled)

- CLK_100  in  1  clock; only clock
- RST  in  1  reset; synchronous, active-high
- s_data  in  BEAT_WIDTH  host beat
- s_valid  in  1  beat valid
- s_last  in  1  final beat of program
- s_ready  out  1  beat accept
- go  in  1  run request (level, sampled in LOADED)
- bram_addr  out  ADDR_WIDTH  BRAM programming address
- bram_din  out  CTRL_WIDTH  BRAM write data
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- START  out  1  tester run request
- COMPLETED  in  1  tester status: 0 only while running
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at run end
- word_count  out  ADDR_WIDTH+1  words written by the current/last load
- err  out  2  sticky: [0] overflow, [1] watchdog timeout
- debug_state  out  3  current FSM state

## Operation
- Beats per word: B = ceil(CTRL_WIDTH/BEAT_WIDTH); B = 3 by default. Beat k fills bits [BEAT_WIDTH*k +: BEAT_WIDTH]. Bits above CTRL_WIDTH are discarded.
- FSM states: IDLE(0), LOAD(1), LOADED(2), RUN(3), DONE(4).
- IDLE:
  - s_ready=1.
  - First accepted beat clears word_count, err and the write pointer, then enters LOAD. That beat counts as beat 0.
- LOAD:
  - s_ready=1.
  - After beat B-1 is accepted, write one word at the pointer, then increment the pointer.
  - s_last on beat k<B-1 zero-pads the remaining beats and writes the partial word.
  - After the write of the s_last word, go to LOADED.
- Overflow: when a word completes after 2^ADDR_WIDTH words have already been written, do not write it and set err[0]. Keep consuming beats until s_last, then go to LOADED. word_count saturates at 2^ADDR_WIDTH.
- LOADED:
  - s_ready=0, bram_* idle.
  - go=1 moves to RUN with START=1.
- RUN:
  - START=1; the loader never asserts bram_en while START=1.
  - Set internal seen_run when COMPLETED=0.
  - When seen_run is set and COMPLETED=1, go to DONE.
- DONE: START=0, done=1 for one cycle, then IDLE.
- The program must end with a word whose bit 0 is 1 (the tester's completion bit). The loader does not enforce this; the watchdog covers it.

## Timing
- A beat is accepted at the posedge where s_valid & s_ready are both high.
- bram_addr, bram_din, bram_en and bram_we are registered. bram_en=bram_we=1 for exactly one cycle, in the cycle after the completing beat is accepted.
- Back-to-back beats never stall s_ready in LOAD.
- LOADED is entered the cycle after the final write.
- START rises 1 cycle after go is sampled.
- DONE is entered the cycle after COMPLETED is seen rising. START falls on entry to DONE.
- Reset values: every output is 0 and the state is IDLE. RST mid-run drops START at the next edge and discards any partial word.
- A go pulse outside LOADED is ignored. s_valid outside IDLE/LOAD is not accepted.

## Configuration
- LOADER_WATCHDOG_EN:
  - Defined: a counter runs in RUN. When it reaches WD_CYCLES without the COMPLETED rising edge, set err[1] and go to DONE (START drops, done pulses).
  - Undefined: no counter, err[1] tied 0, and RUN waits indefinitely.

## Structure
- Package ctrl_loader_pkg holds:
  - the state enum and its encoding
  - the BEATS_PER_WORD constant function
  - the err bit index constants ERR_OVF=0 and ERR_WD=1
- Sub-module beat_packer: beat counter plus a CTRL_WIDTH assembly register. It emits word_valid with the padded word on the completing or last beat.
- The FSM, write pointer, START handshake and watchdog live in the top level.

## Test plan
- Load 2 words, 6 beats 0x1..0x6, s_last on beat 6 -> writes 72'h?_00000002_00000001 truncation-correct at addr 0, word 2 at addr 1; word_count=2; state LOADED.
- s_last on beat 4 -> second word = {40'b0, 32'h4}, word_count=2, no err.
- ADDR_WIDTH=2, 5 words -> 4 writes at addrs 0..3, err[0]=1, word_count=4, fifth word never written.
- Loaded, go=1, model COMPLETED 1→0 for 10 cycles→1 -> START high throughout run, done pulses once, START low, IDLE; no bram_en while START=1.
- LOADER_WATCHDOG_EN, WD_CYCLES=16, COMPLETED stuck 0 -> err[1]=1 and done at cycle 16 after START; without the macro, state stays RUN.
- RST asserted mid-LOAD after beat 2 -> no write, all outputs 0; a new load starts at addr 0.
